rom_stream_reader: RTL and testbench

// - Read-side initiator for the 8x3 synchronous ROM: drives its en/adr, captures data one cycle later.
// - On start, reads len consecutive words from base_adr, wrapping modulo DEPTH.
// - Presents the words as a valid/ready stream with a last flag.
// - Sits between the ROM and any stream consumer; never drops or duplicates a word under backpressure.

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_rd_fifo.sv | 61 ++++++
 rtl/rom_stream_reader.sv | 139 +++++++++++++
 tb/tb_rom_stream_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM stream reader: default geometry and the
// issue-FSM state encoding.
package rom_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rom_rd_fifo.sv
// Two-entry FIFO holding returned ROM words plus their last flag.
// Flush empties it in one cycle and has priority over push and pop.
module rom_rd_fifo #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        assign mem_d[gi] = (push && !flush && (wr_ptr_q == 1'(gi))) ? push_data : mem_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) mem_q[gi] <= '0;
            else        mem_q[gi] <= mem_d[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a burst of consecutive words from a 1-cycle-latency ROM and presents
// them as a valid/ready stream with a last flag; credit-limited to 2 words.
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_adr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic [ADDR_W:0]     accepted_q, accepted_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic                done_q, done_d;

    logic [1:0]          fifo_count;
    logic [DATA_W:0]     fifo_head;
    logic                fifo_push, fifo_pop;
    logic [2:0]          pending;
    logic                abort_act, issue, pop, last_accept, go;

    rom_rd_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_act),
        .push      (fifo_push),
        .push_data ({inflight_last_q, rom_data}),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cur_q           <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            accepted_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_q           <= cur_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            accepted_q      <= accepted_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    always_comb begin
        go          = (state_q == IDLE) && start && (len != '0);
        state_d     = state_q;
        cur_d       = cur_q;
        len_d       = len_q;
        issued_d    = issued_q;
        accepted_d  = accepted_q;
        last_accept = pop && ((accepted_q + ONE) == len_q);

        case (state_q)
            IDLE:    if (go) state_d = ISSUE;
            ISSUE: begin
                if (abort_act || last_accept)             state_d = IDLE;
                else if (issue && (issued_q + ONE) == len_q) state_d = DRAIN;
            end
            DRAIN:   if (abort_act || last_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go) begin
            cur_d      = base_adr;
            len_d      = len;
            issued_d   = '0;
            accepted_d = '0;
        end else begin
            if (issue) begin
                cur_d    = cur_q + 1'b1;
                issued_d = issued_q + ONE;
            end
            if (pop) accepted_d = accepted_q + ONE;
        end

        inflight_d      = issue;
        inflight_last_d = issue && ((issued_q + ONE) == len_q);
        done_d          = ((state_q == IDLE) && start && (len == '0)) || abort_act || last_accept;
    end

    always_comb begin
        abort_act = abort && (state_q != IDLE);
        // Words held plus words in flight must stay below the buffer depth,
        // so a returning ROM word always has a slot.
        pending   = {1'b0, fifo_count} + {2'b00, inflight_q};
        issue     = (state_q == ISSUE) && !abort_act && (issued_q < len_q) && (pending < 3'd2);
        rom_en    = issue;
        rom_adr   = cur_q;

        // An arriving word bypasses the empty buffer to reach the output the
        // same cycle; the word being flushed by abort is never offered.
        out_valid = !abort_act && ((fifo_count != 2'd0) || inflight_q);
        out_data  = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            if (fifo_count != 2'd0) {out_last, out_data} = fifo_head;
            else                    {out_last, out_data} = {inflight_last_q, rom_data};
        end

        pop       = out_valid && out_ready;
        fifo_pop  = pop && (fifo_count != 2'd0);
        fifo_push = inflight_q && !abort_act && !(pop && (fifo_count == 2'd0));
        busy      = (state_q != IDLE);
        done      = done_q;
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a 1-cycle-latency ROM model
// holding mem[i] = i.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] base_adr = '0;
    logic [3:0] len = '0;
    logic       abort = 1'b0;
    logic       rom_en;
    logic [2:0] rom_adr;
    logic [2:0] rom_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [2:0] rom_mem [8];

    int compared = 0;
    int mismatched = 0;

    int got_data[$];
    int got_last[$];
    int got_cyc[$];
    int adr_seq[$];
    int done_cnt, done_cyc, en_viol, en_count, busy_at1, busy_at_done;

    rom_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_adr  (base_adr),
        .len       (len),
        .abort     (abort),
        .rom_en    (rom_en),
        .rom_adr   (rom_adr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_adr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst, recording accepted words, issued addresses and done pulses.
    // Cycle 0 is the cycle start is high; inj_cyc >= 0 pulses a second start.
    task automatic run_burst(input int b, input int l, input int ready_mode, input int inj_cyc);
        int held;
        got_data = {}; got_last = {}; got_cyc = {}; adr_seq = {};
        done_cnt = 0; done_cyc = -1; en_viol = 0; en_count = 0; busy_at1 = -1; busy_at_done = -1;
        held = 0;
        base_adr = 3'(b);
        len = 4'(l);
        start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c == inj_cyc) begin
                start = 1'b1; base_adr = 3'd5; len = 4'd8;
            end else if (c > 0) begin
                start = 1'b0;
            end
            out_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
            #1;
            if (c == 1) busy_at1 = int'(busy);
            if (rom_en) begin
                if (held >= 2) en_viol++;
                adr_seq.push_back(int'(rom_adr));
                en_count++;
                held++;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(int'(out_data));
                got_last.push_back(int'(out_last));
                got_cyc.push_back(c);
                held--;
                $display("  word cyc=%0d data=%0d last=%0d", c, out_data, out_last);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    busy_at_done = int'(busy);
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            step();
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        compared++; if (rom_en !== 1'b0)    begin mismatched++; $display("FAIL reset_rom_en got=%b want=0", rom_en); end
        compared++; if (rom_adr !== 3'd0)   begin mismatched++; $display("FAIL reset_rom_adr got=%0d want=0", rom_adr); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        compared++; if (out_data !== 3'd0)  begin mismatched++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        compared++; if (out_last !== 1'b0)  begin mismatched++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
        compared++; if (done !== 1'b0)      begin mismatched++; $display("FAIL reset_done got=%b want=0", done); end
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_full_burst();
        run_burst(0, 8, 0, -1);
        compared++; if (got_data.size() != 8) begin mismatched++; $display("FAIL t1_count got=%0d want=8", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            compared++; if (got_data[i] != i) begin mismatched++; $display("FAIL t1_data[%0d] got=%0d want=%0d", i, got_data[i], i); end
            compared++; if (got_last[i] != int'(i == 7)) begin mismatched++; $display("FAIL t1_last[%0d] got=%0d want=%0d", i, got_last[i], int'(i == 7)); end
            compared++; if (got_cyc[i] != i + 2) begin mismatched++; $display("FAIL t1_cycle[%0d] got=%0d want=%0d", i, got_cyc[i], i + 2); end
        end
        compared++; if (done_cyc != 10) begin mismatched++; $display("FAIL t1_done_cycle got=%0d want=10", done_cyc); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL t1_done_count got=%0d want=1", done_cnt); end
        compared++; if (busy_at1 != 1) begin mismatched++; $display("FAIL t1_busy_after_start got=%0d want=1", busy_at1); end
        compared++; if (busy_at_done != 0) begin mismatched++; $display("FAIL t1_busy_at_done got=%0d want=0", busy_at_done); end
        compared++; if (en_viol != 0) begin mismatched++; $display("FAIL t1_credit got=%0d want=0", en_viol); end
        $display("test_full_burst done");
    endtask

    task automatic test_wrap();
        int exp_v[4] = '{6, 7, 0, 1};
        run_burst(6, 4, 0, -1);
        compared++; if (adr_seq.size() != 4) begin mismatched++; $display("FAIL t2_issue_count got=%0d want=4", adr_seq.size()); end
        for (int i = 0; i < adr_seq.size() && i < 4; i++) begin
            compared++; if (adr_seq[i] != exp_v[i]) begin mismatched++; $display("FAIL t2_adr[%0d] got=%0d want=%0d", i, adr_seq[i], exp_v[i]); end
        end
        compared++; if (got_data.size() != 4) begin mismatched++; $display("FAIL t2_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            compared++; if (got_data[i] != exp_v[i]) begin mismatched++; $display("FAIL t2_data[%0d] got=%0d want=%0d", i, got_data[i], exp_v[i]); end
            compared++; if (got_last[i] != int'(i == 3)) begin mismatched++; $display("FAIL t2_last[%0d] got=%0d want=%0d", i, got_last[i], int'(i == 3)); end
        end
        compared++; if (done_cyc != 6) begin mismatched++; $display("FAIL t2_done_cycle got=%0d want=6", done_cyc); end
        $display("test_wrap done");
    endtask

    task automatic test_backpressure();
        run_burst(2, 5, 1, -1);
        compared++; if (got_data.size() != 5) begin mismatched++; $display("FAIL t3_count got=%0d want=5", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            compared++; if (got_data[i] != i + 2) begin mismatched++; $display("FAIL t3_data[%0d] got=%0d want=%0d", i, got_data[i], i + 2); end
            compared++; if (got_last[i] != int'(i == 4)) begin mismatched++; $display("FAIL t3_last[%0d] got=%0d want=%0d", i, got_last[i], int'(i == 4)); end
        end
        compared++; if (en_viol != 0) begin mismatched++; $display("FAIL t3_credit got=%0d want=0", en_viol); end
        compared++; if (en_count != 5) begin mismatched++; $display("FAIL t3_issue_count got=%0d want=5", en_count); end
        compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL t3_done_count got=%0d want=1", done_cnt); end
        $display("test_backpressure done");
    endtask

    task automatic test_abort();
        int acc[$];
        int dseen;
        dseen = 0;
        base_adr = 3'd0; len = 4'd8; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            abort = (c == 3);
            #1;
            if (c == 2) begin
                compared++; if (rom_en !== 1'b1) begin mismatched++; $display("FAIL t4_second_issue got=%b want=1", rom_en); end
            end
            if (c == 3) begin
                compared++; if (rom_en !== 1'b0) begin mismatched++; $display("FAIL t4_rom_en_on_abort got=%b want=0", rom_en); end
            end
            if (c == 4) begin
                compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t4_valid_after_abort got=%b want=0", out_valid); end
                compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL t4_done got=%b want=1", done); end
                compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL t4_busy got=%b want=0", busy); end
            end
            if (out_valid && out_ready) acc.push_back(int'(out_data));
            if (done) dseen++;
            step();
        end
        abort = 1'b0;
        compared++; if (acc.size() != 1) begin mismatched++; $display("FAIL t4_accepted got=%0d want=1", acc.size()); end
        if (acc.size() > 0) begin
            compared++; if (acc[0] != 0) begin mismatched++; $display("FAIL t4_first_word got=%0d want=0", acc[0]); end
        end
        compared++; if (dseen != 1) begin mismatched++; $display("FAIL t4_done_count got=%0d want=1", dseen); end
        run_burst(3, 2, 0, -1);
        compared++; if (got_data.size() != 2) begin mismatched++; $display("FAIL t4_restart_count got=%0d want=2", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            compared++; if (got_data[i] != i + 3) begin mismatched++; $display("FAIL t4_restart_data[%0d] got=%0d want=%0d", i, got_data[i], i + 3); end
        end
        $display("test_abort done");
    endtask

    task automatic test_len_zero_and_busy_start();
        base_adr = 3'd4; len = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        #1;
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL t5_len0_done got=%b want=1", done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL t5_len0_busy got=%b want=0", busy); end
        compared++; if (rom_en !== 1'b0) begin mismatched++; $display("FAIL t5_len0_rom_en got=%b want=0", rom_en); end
        step();
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL t5_len0_done_width got=%b want=0", done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL t5_len0_busy_later got=%b want=0", busy); end
        run_burst(0, 3, 0, 3);
        compared++; if (got_data.size() != 3) begin mismatched++; $display("FAIL t5_busy_start_count got=%0d want=3", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            compared++; if (got_data[i] != i) begin mismatched++; $display("FAIL t5_busy_start_data[%0d] got=%0d want=%0d", i, got_data[i], i); end
        end
        compared++; if (en_count != 3) begin mismatched++; $display("FAIL t5_busy_start_issues got=%0d want=3", en_count); end
        compared++; if (done_cyc != 5) begin mismatched++; $display("FAIL t5_busy_start_done_cycle got=%0d want=5", done_cyc); end
        $display("test_len_zero_and_busy_start done");
    endtask

    task automatic test_async_reset();
        int dseen;
        dseen = 0;
        base_adr = 3'd0; len = 4'd8; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (rom_en !== 1'b0)    begin mismatched++; $display("FAIL t6_rom_en got=%b want=0", rom_en); end
        compared++; if (rom_adr !== 3'd0)   begin mismatched++; $display("FAIL t6_rom_adr got=%0d want=0", rom_adr); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t6_out_valid got=%b want=0", out_valid); end
        compared++; if (out_data !== 3'd0)  begin mismatched++; $display("FAIL t6_out_data got=%0d want=0", out_data); end
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("FAIL t6_busy got=%b want=0", busy); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) dseen++;
        end
        rst_n = 1'b1;
        step();
        if (done) dseen++;
        compared++; if (dseen != 0) begin mismatched++; $display("FAIL t6_no_done got=%0d want=0", dseen); end
        run_burst(1, 2, 0, -1);
        compared++; if (got_data.size() != 2) begin mismatched++; $display("FAIL t6_restart_count got=%0d want=2", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            compared++; if (got_data[i] != i + 1) begin mismatched++; $display("FAIL t6_restart_data[%0d] got=%0d want=%0d", i, got_data[i], i + 1); end
        end
        compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL t6_restart_done got=%0d want=1", done_cnt); end
        $display("test_async_reset done");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom_mem[i] = 3'(i);
        #1;
        test_reset();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_abort();
        test_len_zero_and_busy_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
